// File: rtl/mem_fill_writer.sv
// mem_fill_writer: writes a valid/ready byte stream into LENGTH consecutive RAM
// words starting at BASE_ADDR, then optionally reads the region back and
// compares a modulo-2**DATA_W running sum of what was read against what was
// written.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i               begin a fill (honoured in IDLE and DONE only)
//   s_valid_i, s_data_i   source byte stream
//   s_ready_o             combinational: block accepts a byte this cycle
//   w_en_o/w_addr_o/w_data_o  RAM write port (one cycle after acceptance)
//   r_en_o/r_addr_o       RAM read request
//   r_data_i              RAM read data, valid the cycle after r_en_o
//   busy_o, done_o        status (FILL/VERIFY, DONE)
//   error_o               checksum mismatch, sticky until next start
//   count_o               words accepted in the current fill
module mem_fill_writer #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned LENGTH    = 16,
   parameter bit          VERIFY    = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              s_valid_i,
   input  logic [DATA_W-1:0] s_data_i,
   output logic              s_ready_o,
   output logic              w_en_o,
   output logic [ADDR_W-1:0] w_addr_o,
   output logic [DATA_W-1:0] w_data_o,
   output logic              r_en_o,
   output logic [ADDR_W-1:0] r_addr_o,
   input  logic [DATA_W-1:0] r_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic [ADDR_W:0]   count_o
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  LEN_C  = CNT_W'(LENGTH);
   localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(LENGTH - 1);
   localparam logic [ADDR_W-1:0] BASE_C = ADDR_W'(BASE_ADDR);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_VERIFY,
      ST_DONE
   } state_t;

   state_t state_q, state_d;

   logic              w_en_q, w_en_d;
   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic [DATA_W-1:0] w_data_q, w_data_d;
   logic              r_en_q, r_en_d;
   logic [ADDR_W-1:0] r_addr_q, r_addr_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  issue_q, issue_d;
   logic [CNT_W-1:0]  cap_q, cap_d;
   logic [DATA_W-1:0] wsum_q, wsum_d;
   logic [DATA_W-1:0] rsum_q, rsum_d;
   logic [DATA_W-1:0] rsum_add;
   logic              rvalid_q, rvalid_d;
   logic              error_q, error_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              accept;

   // Ready is combinational so a source sees backpressure the same cycle
   assign s_ready_o = (state_q == ST_FILL) && (count_q < LEN_C);
   assign accept    = s_valid_i && s_ready_o;

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and next-value logic for every registered output/datapath reg
   always_comb begin
      state_d  = state_q;
      w_en_d   = 1'b0;
      w_addr_d = w_addr_q;
      w_data_d = w_data_q;
      r_en_d   = 1'b0;
      r_addr_d = r_addr_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      issue_d  = issue_q;
      cap_d    = cap_q;
      wsum_d   = wsum_q;
      rsum_d   = rsum_q;
      rvalid_d = 1'b0;
      error_d  = error_q;
      rsum_add = rsum_q + r_data_i;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_d  = ST_FILL;
               wr_ptr_d = BASE_C;
               rd_ptr_d = BASE_C;
               count_d  = '0;
               issue_d  = '0;
               cap_d    = '0;
               wsum_d   = '0;
               rsum_d   = '0;
               error_d  = 1'b0;
            end
         end

         ST_FILL: begin
            if (accept) begin
               w_en_d   = 1'b1;
               w_addr_d = wr_ptr_q;
               w_data_d = s_data_i;
               wr_ptr_d = wr_ptr_q + ADDR_W'(1);
               count_d  = count_q + CNT_W'(1);
               wsum_d   = wsum_q + s_data_i;
               // Final write pulse lands in the first cycle of the next state
               if (count_q == LAST_C) begin
                  state_d = VERIFY ? ST_VERIFY : ST_DONE;
               end
            end
         end

         ST_VERIFY: begin
            // First VERIFY cycle carries the last write, so reads start after it
            if (issue_q < LEN_C) begin
               r_en_d   = 1'b1;
               r_addr_d = rd_ptr_q;
               rd_ptr_d = rd_ptr_q + ADDR_W'(1);
               issue_d  = issue_q + CNT_W'(1);
            end
            // Read data is valid the cycle after each request
            rvalid_d = r_en_q;
            if (rvalid_q) begin
               rsum_d = rsum_add;
               cap_d  = cap_q + CNT_W'(1);
               if (cap_q == LAST_C) begin
                  error_d = (rsum_add != wsum_q);
                  state_d = ST_DONE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_FILL) || (state_d == ST_VERIFY);
      done_d = (state_d == ST_DONE);
   end

   // Datapath and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         w_en_q   <= 1'b0;
         w_addr_q <= '0;
         w_data_q <= '0;
         r_en_q   <= 1'b0;
         r_addr_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         issue_q  <= '0;
         cap_q    <= '0;
         wsum_q   <= '0;
         rsum_q   <= '0;
         rvalid_q <= 1'b0;
         error_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         w_en_q   <= w_en_d;
         w_addr_q <= w_addr_d;
         w_data_q <= w_data_d;
         r_en_q   <= r_en_d;
         r_addr_q <= r_addr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         issue_q  <= issue_d;
         cap_q    <= cap_d;
         wsum_q   <= wsum_d;
         rsum_q   <= rsum_d;
         rvalid_q <= rvalid_d;
         error_q  <= error_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign w_en_o   = w_en_q;
   assign w_addr_o = w_addr_q;
   assign w_data_o = w_data_q;
   assign r_en_o   = r_en_q;
   assign r_addr_o = r_addr_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign error_o  = error_q;
   assign count_o  = count_q;

endmodule
